bist_checker: RTL

Response analyser paired with the on-board BIST pattern generator. It samples the 4-bit walking pattern from the generator on a sample strobe and locks onto the sequence start. It then compares every sample against an internally regenerated expected sequence, counts mismatches, and reports pass/fail after a programmed number of full periods. It sits between the generator output (or its loop-back path) and the board LEDs/status logic.

---
 rtl/bist_pkg.sv | 41 ++++
 rtl/bist_expected_gen.sv | 31 +++
 rtl/bist_checker.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/bist_pkg.sv
// Shared definitions for the BIST response checker: state encoding, sequence
// geometry, expected-pattern lookup and the MISR step used when BIST_MISR_EN is set.
package bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int SEQ_LEN = 9;
    localparam int PAT_W   = 4;
    localparam int PTR_W   = 4;

    function automatic logic [PAT_W-1:0] expected_pattern(input logic [PTR_W-1:0] pos);
        logic [PAT_W-1:0] pat;
        case (pos)
            4'd0:    pat = 4'b1000;
            4'd1:    pat = 4'b1100;
            4'd2:    pat = 4'b1110;
            4'd3:    pat = 4'b1111;
            4'd4:    pat = 4'b1110;
            4'd5:    pat = 4'b1100;
            4'd6:    pat = 4'b1000;
            4'd7:    pat = 4'b0000;
            4'd8:    pat = 4'b0000;
            default: pat = 4'b0000;
        endcase
        return pat;
    endfunction

    // Galois-form step of x^4+x+1 with the sample folded in.
    function automatic logic [PAT_W-1:0] misr_next(input logic [PAT_W-1:0] sig,
                                                   input logic [PAT_W-1:0] data);
        logic fb;
        fb = sig[3];
        return {sig[2], sig[1], sig[0] ^ fb, fb} ^ data;
    endfunction

endpackage

// File: rtl/bist_expected_gen.sv
// Regenerates the expected walking pattern from a mod-SEQ_LEN position pointer.
module bist_expected_gen
    import bist_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             advance,
    output logic [PAT_W-1:0] expected
);

    localparam logic [PTR_W-1:0] LAST_POS = PTR_W'(SEQ_LEN - 1);

    logic [PTR_W-1:0] ptr_r;

    // Position pointer: clear wins over advance, wraps after the last position.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= 4'd0;
        end else if (clear) begin
            ptr_r <= 4'd0;
        end else if (advance) begin
            ptr_r <= (ptr_r == LAST_POS) ? 4'd0 : ptr_r + 4'd1;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign expected = expected_pattern(ptr_r);

endmodule

// File: rtl/bist_checker.sv
// BIST response analyser: locks on the walking-pattern start, checks PERIODS full
// periods and reports pass/fail. Define BIST_MISR_EN to add the signature output.
module bist_checker
    import bist_pkg::*;
#(
    parameter int PERIODS      = 2,
    parameter int ERR_W        = 8,
    parameter int SYNC_TIMEOUT = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sample_en,
    input  logic [3:0]       din,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic             mismatch,
    output logic [ERR_W-1:0] err_cnt
`ifdef BIST_MISR_EN
    ,
    output logic [3:0]       signature
`endif
);

    localparam int TOTAL  = PERIODS * SEQ_LEN;
    localparam int CNT_W  = $clog2(TOTAL + 1);
    localparam int SYNC_W = $clog2(SYNC_TIMEOUT + 1);

    localparam logic [CNT_W-1:0]  TOTAL_C    = CNT_W'(TOTAL);
    localparam logic [SYNC_W-1:0] SYNC_LIMIT = SYNC_W'(SYNC_TIMEOUT);
    localparam logic [ERR_W-1:0]  ERR_MAX    = {ERR_W{1'b1}};
    localparam logic [PAT_W-1:0]  LOCK_PAT   = 4'b1000;
    localparam logic [PAT_W-1:0]  ZERO_PAT   = 4'b0000;

    state_t            state_r;
    logic [PAT_W-1:0]  prev_r;
    logic [SYNC_W-1:0] sync_cnt_r;
    logic [CNT_W-1:0]  sample_cnt_r;

    logic              arm_s;
    logic              lock_s;
    logic              check_s;
    logic              miss_s;
    logic [PAT_W-1:0]  expected_s;
    logic [SYNC_W-1:0] sync_inc_s;
    logic [CNT_W-1:0]  sample_inc_s;
    logic [ERR_W-1:0]  err_inc_s;

    assign arm_s        = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    assign lock_s       = (state_r == ST_SYNC) && sample_en && (din == LOCK_PAT) && (prev_r == ZERO_PAT);
    assign check_s      = (state_r == ST_CHECK) && sample_en;
    assign miss_s       = check_s && (din != expected_s);
    assign sync_inc_s   = sync_cnt_r + SYNC_W'(1);
    assign sample_inc_s = sample_cnt_r + CNT_W'(1);
    assign err_inc_s    = (err_cnt == ERR_MAX) ? err_cnt : err_cnt + ERR_W'(1);

    // The lock sample is position 0, so advancing on lock leaves the pointer at 1.
    bist_expected_gen u_expected_gen (
        .clk      (clk),
        .rst      (rst),
        .clear    (arm_s),
        .advance  (lock_s || check_s),
        .expected (expected_s)
    );

    // Control FSM with all status outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            prev_r       <= 4'b0000;
            sync_cnt_r   <= '0;
            sample_cnt_r <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            timeout      <= 1'b0;
            mismatch     <= 1'b0;
            err_cnt      <= '0;
`ifdef BIST_MISR_EN
            signature    <= 4'b0000;
`endif
        end else begin
            mismatch <= 1'b0;
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_r      <= ST_SYNC;
                        prev_r       <= 4'b0000;
                        sync_cnt_r   <= '0;
                        sample_cnt_r <= '0;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        pass         <= 1'b0;
                        timeout      <= 1'b0;
                        err_cnt      <= '0;
`ifdef BIST_MISR_EN
                        signature    <= 4'b0000;
`endif
                    end
                end
                ST_SYNC: begin
                    if (lock_s) begin
                        state_r      <= ST_CHECK;
                        sample_cnt_r <= CNT_W'(1);
`ifdef BIST_MISR_EN
                        signature    <= misr_next(signature, din);
`endif
                    end else if (sample_en) begin
                        sync_cnt_r <= sync_inc_s;
                        prev_r     <= din;
                        if (sync_inc_s == SYNC_LIMIT) begin
                            state_r <= ST_DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            timeout <= 1'b1;
                            pass    <= 1'b0;
                        end
                    end
                end
                ST_CHECK: begin
                    if (check_s) begin
                        sample_cnt_r <= sample_inc_s;
`ifdef BIST_MISR_EN
                        signature    <= misr_next(signature, din);
`endif
                        if (miss_s) begin
                            mismatch <= 1'b1;
                            err_cnt  <= err_inc_s;
                        end
                        // Verdict must include the compare happening this cycle.
                        if (sample_inc_s == TOTAL_C) begin
                            state_r <= ST_DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            pass    <= !miss_s && (err_cnt == '0) && !timeout;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
